// File: rtl/neopixel_multi_driver.sv
// Multi-string WS2812 driver: host writes land in a staging memory that is copied to a display
// memory at frame start, then every string is shifted out bit-synchronously with brightness scaling.
module neopixel_multi_driver #(
  parameter int          C_CHANNELS = 4,
  parameter int          C_PIXELS   = 12,
  parameter int          C_RGBW     = 0,
  parameter int unsigned C_FREQ_HZ  = 125000000,
  parameter int unsigned C_T0H_NS   = 400,
  parameter int unsigned C_T1H_NS   = 800,
  parameter int unsigned C_TBIT_NS  = 1250,
  parameter int unsigned C_LATCH_US = 120,
  localparam int CW = (C_CHANNELS > 1) ? $clog2(C_CHANNELS) : 1,
  localparam int PW = (C_PIXELS > 1) ? $clog2(C_PIXELS) : 1
) (
  input  logic                  neopixel_clock,
  input  logic                  neopixel_reset_n,
  input  logic                  wr_en,
  input  logic [CW-1:0]         wr_channel,
  input  logic [PW-1:0]         wr_pixel,
  input  logic [31:0]           wr_data,
  output logic                  wr_ready,
  input  logic                  frame_start,
  input  logic                  free_run,
  input  logic [31:0]           idle_cycles,
  input  logic [7:0]            brightness,
  output logic                  busy,
  output logic                  frame_done,
  output logic [C_CHANNELS-1:0] neopixel_drive
);

  localparam longint unsigned FREQ = 64'(C_FREQ_HZ);
  localparam int unsigned T0H   = 32'((FREQ * 64'(C_T0H_NS)) / 64'd1000000000);
  localparam int unsigned T1H   = 32'((FREQ * 64'(C_T1H_NS)) / 64'd1000000000);
  localparam int unsigned TBIT  = 32'((FREQ * 64'(C_TBIT_NS)) / 64'd1000000000);
  localparam int unsigned LATCH = 32'((FREQ * 64'(C_LATCH_US)) / 64'd1000000);
  localparam int unsigned BPP   = (C_RGBW != 0) ? 32 : 24;

  localparam logic [15:0]   T0H16     = 16'(T0H);
  localparam logic [15:0]   T1H16     = 16'(T1H);
  localparam logic [15:0]   TBIT_M1   = 16'(TBIT - 1);
  localparam logic [4:0]    BPP_M1    = 5'(BPP - 1);
  localparam logic [31:0]   LATCH_M1  = 32'(LATCH - 1);
  localparam logic [31:0]   PIX_LAST  = 32'(C_PIXELS - 1);
  localparam logic [PW-1:0] PIX_M1    = PW'(C_PIXELS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_COPY = 3'd1;
  localparam logic [2:0] S_PRE  = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_POST = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  logic [2:0]                   state_q, state_d;
  logic [31:0]                  cnt_q, cnt_d;
  logic [15:0]                  bit_cnt_q, bit_cnt_d;
  logic [4:0]                   bit_idx_q, bit_idx_d;
  logic [PW-1:0]                pix_q, pix_d;
  logic [7:0]                   bright_q, bright_d;
  logic [C_CHANNELS-1:0][31:0]  shift_q, shift_d;
  logic [C_CHANNELS-1:0]        drive_q, drive_d;
  logic                         busy_q, busy_d;
  logic                         frame_done_q, frame_done_d;
  logic                         wr_ready_q, wr_ready_d;
  logic                         load_en;
  logic [PW-1:0]                load_idx;
  logic                         copy_en;
  logic [PW-1:0]                copy_idx;
  logic                         wr_accept;

  logic [31:0] staging_mem [C_CHANNELS][C_PIXELS];
  logic [31:0] display_mem [C_CHANNELS][C_PIXELS];

  function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(c) * (16'(b) + 16'd1);
    return prod[15:8];
  endfunction

  // Shifter word is always {G,R,B,W}; in RGB mode the W slot is never reached before reload.
  function automatic logic [31:0] pack_pixel(input logic [31:0] w, input logic [7:0] b);
    logic [7:0] wbyte;
    wbyte = (C_RGBW != 0) ? scale_byte(w[31:24], b) : 8'h00;
    return {scale_byte(w[15:8], b), scale_byte(w[23:16], b), scale_byte(w[7:0], b), wbyte};
  endfunction

  assign wr_accept = wr_en && wr_ready_q &&
                     (32'(wr_channel) < 32'(C_CHANNELS)) && (32'(wr_pixel) < 32'(C_PIXELS));
  assign copy_en   = (state_q == S_COPY);
  assign copy_idx  = cnt_q[PW-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    pix_d     = pix_q;
    bright_d  = bright_q;
    shift_d   = shift_q;
    load_en   = 1'b0;
    load_idx  = '0;
    case (state_q)
      S_IDLE: begin
        if (frame_start || free_run) begin
          state_d  = S_COPY;
          cnt_d    = '0;
          bright_d = brightness;
        end
      end
      S_COPY: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == PIX_LAST) begin
          state_d = S_PRE;
          cnt_d   = '0;
        end
      end
      S_PRE: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == LATCH_M1) begin
          state_d   = S_SEND;
          cnt_d     = '0;
          bit_cnt_d = '0;
          bit_idx_d = '0;
          pix_d     = '0;
          load_en   = 1'b1;
        end
      end
      S_SEND: begin
        bit_cnt_d = bit_cnt_q + 16'd1;
        if (bit_cnt_q == TBIT_M1) begin
          bit_cnt_d = '0;
          bit_idx_d = bit_idx_q + 5'd1;
          for (int ch = 0; ch < C_CHANNELS; ch++) shift_d[ch] = {shift_q[ch][30:0], 1'b0};
          if (bit_idx_q == BPP_M1) begin
            bit_idx_d = '0;
            if (pix_q == PIX_M1) begin
              state_d = S_POST;
              cnt_d   = '0;
            end else begin
              pix_d    = pix_q + PW'(1);
              load_en  = 1'b1;
              load_idx = pix_q + PW'(1);
            end
          end
        end
      end
      S_POST: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == LATCH_M1) begin
          cnt_d = '0;
          if (!free_run) begin
            state_d = S_IDLE;
          end else if (idle_cycles == 32'd0) begin
            state_d  = S_COPY;
            bright_d = brightness;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 32'd1;
        if (!free_run) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_d >= idle_cycles) begin
          state_d  = S_COPY;
          cnt_d    = '0;
          bright_d = brightness;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (load_en) begin
      for (int ch = 0; ch < C_CHANNELS; ch++) shift_d[ch] = pack_pixel(display_mem[ch][load_idx], bright_q);
    end
    // Outputs are decoded from next-state so the registered pins line up with state_q.
    busy_d       = (state_d != S_IDLE);
    wr_ready_d   = (state_d != S_COPY);
    frame_done_d = (state_d == S_POST) && (cnt_d == LATCH_M1);
    drive_d      = '0;
    for (int ch = 0; ch < C_CHANNELS; ch++) begin
      drive_d[ch] = (state_d == S_SEND) && (bit_cnt_d < (shift_d[ch][31] ? T1H16 : T0H16));
    end
  end

  always_ff @(posedge neopixel_clock) begin
    if (!neopixel_reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      pix_q        <= '0;
      drive_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      wr_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      pix_q        <= pix_d;
      drive_q      <= drive_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      wr_ready_q   <= wr_ready_d;
    end
  end

  always_ff @(posedge neopixel_clock) begin
    bright_q <= bright_d;
    shift_q  <= shift_d;
  end

  always_ff @(posedge neopixel_clock) begin
    if (wr_accept) staging_mem[wr_channel][wr_pixel] <= wr_data;
    if (copy_en) begin
      for (int ch = 0; ch < C_CHANNELS; ch++) display_mem[ch][copy_idx] <= staging_mem[ch][copy_idx];
    end
  end

  assign wr_ready       = wr_ready_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;
  assign neopixel_drive = drive_q;

endmodule

// File: tb/tb_neopixel_multi_driver.sv
// Bench for neopixel_multi_driver: 3 strings x 2 RGB pixels at 125 MHz with a shortened latch,
// checked cycle by cycle against a frame-level model of the serial waveform.
`timescale 1ns/1ps
module tb_neopixel_multi_driver;
  localparam int NCH        = 3;
  localparam int NPX        = 2;
  localparam int FREQ       = 125000000;
  localparam int LATCH_US   = 2;
  localparam int T0H        = (FREQ / 1000) * 400 / 1000000;
  localparam int T1H        = (FREQ / 1000) * 800 / 1000000;
  localparam int TBIT       = (FREQ / 1000) * 1250 / 1000000;
  localparam int LATCH      = (FREQ / 1000000) * LATCH_US;
  localparam int SEND_START = NPX + LATCH + 1;
  localparam int SEND_LEN   = NPX * 24 * TBIT;
  localparam int FRAME_LEN  = NPX + 2 * LATCH + SEND_LEN;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wr_en;
  logic [1:0]     wr_channel;
  logic [0:0]     wr_pixel;
  logic [31:0]    wr_data;
  logic           wr_ready;
  logic           frame_start;
  logic           free_run;
  logic [31:0]    idle_cycles;
  logic [7:0]     brightness;
  logic           busy;
  logic           frame_done;
  logic [NCH-1:0] drive;

  logic [31:0] stage_m [NCH][NPX];
  logic [31:0] disp_m  [NCH][NPX];
  int vectors = 0;
  int miscompares = 0;

  neopixel_multi_driver #(
    .C_CHANNELS(NCH), .C_PIXELS(NPX), .C_RGBW(0), .C_FREQ_HZ(FREQ),
    .C_T0H_NS(400), .C_T1H_NS(800), .C_TBIT_NS(1250), .C_LATCH_US(LATCH_US)
  ) dut (
    .neopixel_clock(clk), .neopixel_reset_n(rst_n),
    .wr_en(wr_en), .wr_channel(wr_channel), .wr_pixel(wr_pixel), .wr_data(wr_data),
    .wr_ready(wr_ready), .frame_start(frame_start), .free_run(free_run),
    .idle_cycles(idle_cycles), .brightness(brightness), .busy(busy),
    .frame_done(frame_done), .neopixel_drive(drive)
  );

  always #4 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Bit n of the frame on string ch: pixel order, G,R,B bytes, MSB first, brightness-scaled.
  function automatic bit exp_bit(input int ch, input int n, input int bri);
    int px, pos, c;
    logic [31:0] w;
    px  = n / 24;
    pos = n % 24;
    w   = disp_m[ch][px];
    case (pos / 8)
      0:       c = int'(w[15:8]);
      1:       c = int'(w[23:16]);
      default: c = int'(w[7:0]);
    endcase
    c = (c * (bri + 1)) / 256;
    return ((c >> (7 - pos % 8)) & 1) != 0;
  endfunction

  task automatic write_px(input int ch, input int px, input logic [31:0] data);
    wr_channel = 2'(ch);
    wr_pixel   = 1'(px);
    wr_data    = data;
    wr_en      = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (ch < NCH && px < NPX) stage_m[ch][px] = data;
  endtask

  task automatic start_frame(input int bri);
    brightness  = 8'(bri);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    disp_m = stage_m;
  endtask

  // Called between the negedges of frame cycle 0 (request cycle) and cycle 1.
  task automatic check_frame(input string name, input int bri);
    int hi [NCH];
    int bad [NCH];
    int quiet_bad, busy_bad, rdy_bad, done_cnt, done_at, s, n, t;
    bit e;
    quiet_bad = 0; busy_bad = 0; rdy_bad = 0; done_cnt = 0; done_at = -1;
    for (int ch = 0; ch < NCH; ch++) begin hi[ch] = 0; bad[ch] = 0; end
    for (int k = 1; k <= FRAME_LEN; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_bad++;
      if (wr_ready !== ((k > NPX) ? 1'b1 : 1'b0)) rdy_bad++;
      if (frame_done === 1'b1) begin done_cnt++; done_at = k; end
      s = k - SEND_START;
      if (s < 0 || s >= SEND_LEN) begin
        if (drive !== '0) quiet_bad++;
      end else begin
        n = s / TBIT;
        t = s % TBIT;
        for (int ch = 0; ch < NCH; ch++) begin
          e = exp_bit(ch, n, bri);
          if (drive[ch] === 1'b1) hi[ch]++;
          if (drive[ch] !== ((t < (e ? T1H : T0H)) ? 1'b1 : 1'b0)) bad[ch]++;
          if (t == TBIT - 1) begin
            vectors++;
            if (bad[ch] != 0) begin
              miscompares++;
              $display("FAIL %s ch%0d bit%0d: high %0d cycles (%0d cycles off-shape), required high %0d of %0d",
                       name, ch, n, hi[ch], bad[ch], e ? T1H : T0H, TBIT);
            end
            hi[ch] = 0;
            bad[ch] = 0;
          end
        end
      end
    end
    vectors++;
    if (quiet_bad != 0) begin
      miscompares++;
      $display("FAIL %s latch_low: %0d cycles with drive high, required 0", name, quiet_bad);
    end
    vectors++;
    if (done_cnt != 1 || done_at != FRAME_LEN) begin
      miscompares++;
      $display("FAIL %s frame_done: %0d pulses, last at cycle %0d, required 1 at cycle %0d",
               name, done_cnt, done_at, FRAME_LEN);
    end
    vectors++;
    if (busy_bad != 0) begin
      miscompares++;
      $display("FAIL %s busy: %0d cycles low, required 0", name, busy_bad);
    end
    vectors++;
    if (rdy_bad != 0) begin
      miscompares++;
      $display("FAIL %s wr_ready: %0d cycles wrong, required low for exactly %0d cycles", name, rdy_bad, NPX);
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if ({drive, busy, wr_ready, frame_done} !== {{NCH{1'b0}}, 1'b0, 1'b1, 1'b0}) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL %s: %0d cycles not idle (drive=0 busy=0 wr_ready=1 frame_done=0 required)", name, bad);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if ({drive, busy, wr_ready, frame_done} !== {{NCH{1'b0}}, 1'b0, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL reset cyc%0d: drive=%b busy=%b wr_ready=%b frame_done=%b, required 000 0 1 0",
                 i, drive, busy, wr_ready, frame_done);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1; wr_en = 1'b0; frame_start = 1'b0;
    check_idle("post_reset_idle", 5);
    @(posedge clk); #1;
  endtask

  task automatic test_frame_basic();
    write_px(0, 0, 32'h00FF0000);
    write_px(0, 1, $urandom);
    write_px(1, 0, $urandom);
    write_px(1, 1, 32'h00000001);
    write_px(2, 0, $urandom);
    write_px(2, 1, $urandom);
    start_frame(255);
    check_frame("basic", 255);
    @(posedge clk); #1;
  endtask

  task automatic test_brightness();
    start_frame(127);
    check_frame("bright127", 127);
    @(posedge clk); #1;
  endtask

  task automatic test_write_during_copy();
    int bri, waits;
    logic [31:0] nd;
    bri = int'($urandom_range(0, 255));
    nd  = $urandom;
    start_frame(bri);
    fork
      check_frame("copy_lock", bri);
      begin
        waits = 0;
        wr_channel = 2'd0; wr_pixel = 1'b1; wr_data = nd; wr_en = 1'b1;
        do begin @(negedge clk); waits++; end while (wr_ready !== 1'b1 && waits < 20);
        vectors++;
        if (waits != NPX + 1) begin
          miscompares++;
          $display("FAIL wr_hold: wr_ready seen after %0d cycles, required %0d", waits, NPX + 1);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        stage_m[0][1] = nd;
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic test_free_run();
    int bri, gap_bad;
    bri = int'($urandom_range(1, 255));
    brightness  = 8'(bri);
    idle_cycles = 32'd1000;
    free_run    = 1'b1;
    @(posedge clk); #1;
    disp_m = stage_m;
    check_frame("free_a", bri);
    gap_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if ({drive, busy, wr_ready, frame_done} !== {{NCH{1'b0}}, 1'b1, 1'b1, 1'b0}) gap_bad++;
    end
    vectors++;
    if (gap_bad != 0) begin
      miscompares++;
      $display("FAIL free_gap: %0d gap cycles wrong, required drive=0 busy=1 no frame_done", gap_bad);
    end
    disp_m = stage_m;
    fork
      check_frame("free_b", bri);
      begin
        repeat (SEND_START + 3000) @(negedge clk);
        free_run = 1'b0;
      end
    join
    check_idle("free_stop_idle", 10);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_send();
    int bad;
    write_px(1, 0, $urandom);
    write_px(2, 1, $urandom);
    start_frame(255);
    repeat (SEND_START + 1500) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({drive, busy, wr_ready, frame_done} !== {{NCH{1'b0}}, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_send: drive=%b busy=%b wr_ready=%b frame_done=%b, required 000 0 1 0",
               drive, busy, wr_ready, frame_done);
    end
    bad = 0;
    repeat (3) begin @(negedge clk); if (frame_done !== 1'b0 || drive !== '0) bad++; end
    rst_n = 1'b1;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL reset_hold: %0d cycles with activity, required 0", bad);
    end
    check_idle("reset_release_idle", 20);
    @(posedge clk); #1;
    write_px(3, 0, $urandom);
    write_px(0, 0, $urandom);
    start_frame(int'($urandom_range(0, 255)));
    check_frame("after_reset", int'(brightness));
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b1; wr_channel = 2'd3; wr_pixel = 1'b0; wr_data = 32'hDEADBEEF;
    frame_start = 1'b1; free_run = 1'b0; idle_cycles = 32'd0; brightness = 8'd255;
    test_reset();
    test_frame_basic();
    test_brightness();
    test_write_during_copy();
    test_free_run();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
